// File: rtl/debug_uart_pkg.sv
// debug_uart_pkg: shared state encoding and bit-timing helper for the debug UART receiver
package debug_uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction
endpackage

// File: rtl/debug_uart_rx_if.sv
// debug_uart_rx_if: valid/ready byte stream from the receiver to its consumer
interface debug_uart_rx_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  modport master (output out_data, output out_valid, input out_ready);
  modport slave (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous single-bit input
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);
  logic [1:0] r_sync;
  // shift the raw input through two flops, presetting both to the idle level
  always_ff @(posedge clk or posedge reset)
    if (reset) r_sync <= {2{RST_VAL}};
    else r_sync <= {r_sync[0], i_d};
  assign o_q = r_sync[1];
endmodule

// File: rtl/debug_uart_rx.sv
// debug_uart_rx: 8N1 UART receiver with mid-bit sampling and a one-deep valid/ready output
module debug_uart_rx
  import debug_uart_pkg::*;
#(
  parameter int CLK_HZ = 74250000,
  parameter int BAUD   = 115200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  debug_uart_rx_if.master  dout,
  output logic             framing_error,
  output logic             overrun,
  output logic             busy
);
  localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CPB - 1);
  if (CPB < 4) begin : g_cpb_check
    $error("debug_uart_rx: CLKS_PER_BIT must be at least 4");
  end
  logic          w_rx_s;
  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [2:0]    r_bits, w_bits;
  logic [7:0]    r_shift, w_shift;
  logic          w_done, w_ferr;
  logic [7:0]    r_data;
  logic          r_valid, r_ferr, r_ovr;
  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (rx),
    .o_q   (w_rx_s)
  );
  // receiver state, bit timer, bit index and shift register
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bits  <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_bits  <= w_bits;
      r_shift <= w_shift;
    end
  // next-state: half-bit wait to the start-bit centre, then one sample per bit period
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_bits  = r_bits;
    w_shift = r_shift;
    w_done  = 1'b0;
    w_ferr  = 1'b0;
    case (r_state)
      IDLE:
        if (!w_rx_s) begin
          w_state = START;
          w_cnt   = HALF;
        end
      START:
        if (r_cnt != '0) w_cnt = r_cnt - 1'b1;
        else if (w_rx_s) w_state = IDLE;
        else begin
          w_state = DATA;
          w_cnt   = FULL;
          w_bits  = '0;
        end
      DATA:
        if (r_cnt != '0) w_cnt = r_cnt - 1'b1;
        else begin
          w_shift = {w_rx_s, r_shift[7:1]};
          w_cnt   = FULL;
          w_bits  = r_bits + 3'd1;
          w_state = (r_bits == 3'd7) ? STOP : DATA;
        end
      STOP:
        if (r_cnt != '0) w_cnt = r_cnt - 1'b1;
        else begin
          w_done  = w_rx_s;
          w_ferr  = !w_rx_s;
          w_state = w_rx_s ? IDLE : WAIT_IDLE;
        end
      WAIT_IDLE:
        if (w_rx_s) w_state = IDLE;
      default: w_state = IDLE;
    endcase
  end
  // output holding register: a completed byte loads only if the slot is free or being drained
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_ferr;
      r_ovr  <= w_done && r_valid && !dout.out_ready;
      if (w_done && (!r_valid || dout.out_ready)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (dout.out_ready) r_valid <= 1'b0;
    end
  assign dout.out_data  = r_data;
  assign dout.out_valid = r_valid;
  assign framing_error  = r_ferr;
  assign overrun        = r_ovr;
  assign busy           = r_state != IDLE;
endmodule
